// File: rtl/raster_tri_scheduler.sv
// Triangle scheduler between transform and rasterizer: FIFO-buffers triangles, issues one at a time,
// tracks completion and frame_done. Optional off-screen culling when CULL_OFFSCREEN_EN is defined.
module raster_tri_scheduler #(
   parameter int DEPTH        = 4,
   parameter int TRI_W        = 360,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [TRI_W-1:0] tri_in,
   input  logic             tri_last,
   input  logic             tri_valid,
   output logic             tri_ready,
   input  logic [25:0]      fb_base,
   input  logic             frame_start,
   output logic [TRI_W-1:0] rast_tri,
   output logic [25:0]      rast_addr,
   output logic             rast_valid,
   output logic             rast_done,
   input  logic             rast_busy,
   output logic             frame_done,
   output logic [15:0]      issued_cnt,
   output logic [15:0]      culled_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   // FIFO entries carry the triangle with its last flag in bit 0.
   logic [TRI_W:0]  r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_alive;

   state_t          r_state;
   logic [TW-1:0]   r_tmo;
   logic            r_fb_pend;
   logic [25:0]     r_fb_pend_addr;

   logic            w_push;
   logic            w_pop;
   logic            w_empty;
   logic            w_issue;
   logic            w_complete;
   logic [TRI_W:0]  w_head;

   assign tri_ready = r_alive && (r_count != CW'(DEPTH));
   assign w_push    = tri_valid && tri_ready;
   assign w_empty   = (r_count == '0);
   assign w_head    = r_mem[r_rd_ptr];

   assign w_complete = ((r_state == S_WAIT_BUSY) && !rast_busy && (r_tmo == TW'(BUSY_TIMEOUT - 1)))
                    || ((r_state == S_WAIT_DONE) && !rast_busy);

`ifdef CULL_OFFSCREEN_EN
   logic signed [15:0] w_vx [3];
   logic signed [15:0] w_vy [3];
   logic               w_cull;
   logic               w_all_left;
   logic               w_all_right;
   logic               w_all_above;
   logic               w_all_below;

   // Integer part of a 16.16 coordinate is its upper 16 bits.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         w_vx[i] = w_head[TRI_W - 96*i -: 16];
         w_vy[i] = w_head[TRI_W - 32 - 96*i -: 16];
      end
   end

   assign w_all_left  = w_vx[0][15] && w_vx[1][15] && w_vx[2][15];
   assign w_all_right = (w_vx[0] > 16'sd639) && (w_vx[1] > 16'sd639) && (w_vx[2] > 16'sd639);
   assign w_all_above = w_vy[0][15] && w_vy[1][15] && w_vy[2][15];
   assign w_all_below = (w_vy[0] > 16'sd479) && (w_vy[1] > 16'sd479) && (w_vy[2] > 16'sd479);

   assign w_cull  = (r_state == S_IDLE) && !w_empty
                 && (w_all_left || w_all_right || w_all_above || w_all_below);
   assign w_issue = (r_state == S_IDLE) && !w_empty && !rast_busy && !w_cull;
   assign w_pop   = w_issue || w_cull;
`else
   assign w_issue    = (r_state == S_IDLE) && !w_empty && !rast_busy;
   assign w_pop      = w_issue;
   assign culled_cnt = '0;
`endif

   // NOTE: storage array has no reset; only pointers and count define validity.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= {tri_in, tri_last};
   end

   // NOTE: all sequential state uses non-blocking assignments so every block sees pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_alive  <= 1'b0;
      end else begin
         r_alive <= 1'b1;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_tmo          <= '0;
         r_fb_pend      <= 1'b0;
         r_fb_pend_addr <= '0;
         rast_tri       <= '0;
         rast_addr      <= '0;
         rast_valid     <= 1'b0;
         rast_done      <= 1'b0;
         frame_done     <= 1'b0;
         issued_cnt     <= '0;
`ifdef CULL_OFFSCREEN_EN
         culled_cnt     <= '0;
`endif
      end else begin
         rast_valid <= 1'b0;
         frame_done <= 1'b0;

         // A frame base arriving mid-triangle waits until the scheduler is idle again.
         if (frame_start && (r_state != S_IDLE)) begin
            r_fb_pend      <= 1'b1;
            r_fb_pend_addr <= fb_base;
         end

         case (r_state)
            S_IDLE: begin
               if (frame_start) rast_addr <= fb_base;
`ifdef CULL_OFFSCREEN_EN
               if (w_cull) begin
                  culled_cnt <= culled_cnt + 1'b1;
                  frame_done <= w_head[0];
               end
`endif
               if (w_issue) begin
                  rast_tri   <= w_head[TRI_W:1];
                  rast_done  <= w_head[0];
                  rast_valid <= 1'b1;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               issued_cnt <= issued_cnt + 1'b1;
               r_tmo      <= '0;
               r_state    <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (rast_busy)       r_state <= S_WAIT_DONE;
               else if (!w_complete) r_tmo  <= r_tmo + 1'b1;
            end
            S_WAIT_DONE: begin
               r_state <= r_state;
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_complete) begin
            frame_done <= rast_done;
            r_state    <= S_IDLE;
            r_fb_pend  <= 1'b0;
            if (frame_start)    rast_addr <= fb_base;
            else if (r_fb_pend) rast_addr <= r_fb_pend_addr;
         end
      end
   end

endmodule

// File: tb/tb_raster_tri_scheduler.sv
// Scoreboard bench for raster_tri_scheduler: stimulus queues expected issues, a monitor pops and compares.
// Culling expectations follow CULL_OFFSCREEN_EN.
module tb_raster_tri_scheduler;

   localparam int TRI_W = 360;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [TRI_W-1:0] tri_in = '0;
   logic             tri_last = 1'b0;
   logic             tri_valid = 1'b0;
   logic             tri_ready;
   logic [25:0]      fb_base = '0;
   logic             frame_start = 1'b0;
   logic [TRI_W-1:0] rast_tri;
   logic [25:0]      rast_addr;
   logic             rast_valid;
   logic             rast_done;
   logic             rast_busy;
   logic             frame_done;
   logic [15:0]      issued_cnt;
   logic [15:0]      culled_cnt;

   raster_tri_scheduler #(.DEPTH(4), .TRI_W(TRI_W), .BUSY_TIMEOUT(15)) dut (
      .clock(clock), .reset(reset),
      .tri_in(tri_in), .tri_last(tri_last), .tri_valid(tri_valid), .tri_ready(tri_ready),
      .fb_base(fb_base), .frame_start(frame_start),
      .rast_tri(rast_tri), .rast_addr(rast_addr), .rast_valid(rast_valid), .rast_done(rast_done),
      .rast_busy(rast_busy), .frame_done(frame_done),
      .issued_cnt(issued_cnt), .culled_cnt(culled_cnt)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [TRI_W-1:0] tv;
      logic             last;
      logic [25:0]      addr;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int cyc = 0;
   int n_checks = 0, n_pass = 0, n_fail = 0;
   int n_issue = 0, exp_issued = 0, fd_expect = 0, fd_seen = 0;
   int fd_cyc = 0, last_issue_cyc = 0, prev_issue_cyc = 0, fall_cyc = 0;
   int busy_len = 0, busy_cnt = 0;
   bit hold_busy = 0, have_issue = 0;
   logic [25:0] exp_addr = '0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic check_w(input string name, input logic [TRI_W-1:0] act, input logic [TRI_W-1:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic logic [TRI_W-1:0] mk(input int x1, input int y1, input int x2, input int y2,
                                           input int x3, input int y3, input logic [23:0] col);
      return {32'(x1 * 65536), 32'(y1 * 65536), 32'd0,
              32'(x2 * 65536), 32'(y2 * 65536), 32'd1,
              32'(x3 * 65536), 32'(y3 * 65536), 32'd2,
              col, col ^ 24'h00ff00, col ^ 24'hff0000};
   endfunction

   // Monitor: every issue strobe is matched against the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clock);
         if (reset && rast_valid) begin
            if (exp_q.size() == 0) check("unexpected_issue", 32'd1, 32'd0);
            else begin
               mon_e = exp_q.pop_front();
               check_w("issue_tri", rast_tri, mon_e.tv);
               check("issue_done", 32'(rast_done), 32'(mon_e.last));
               check("issue_addr", 32'(rast_addr), 32'(mon_e.addr));
               check("issued_cnt_at_issue", 32'(issued_cnt), 32'(exp_issued));
               exp_issued++;
               if (have_issue) check("issue_gap_ge4", 32'((cyc - last_issue_cyc) >= 4), 32'd1);
               if (rast_done) fd_expect++;
            end
            prev_issue_cyc = last_issue_cyc;
            last_issue_cyc = cyc;
            have_issue = 1;
            n_issue++;
         end
         if (reset && frame_done) begin
            fd_seen++;
            fd_cyc = cyc;
         end
      end
   end

   // Rasterizer model: raises busy for busy_len cycles after each issue (0 = never raises).
   initial begin
      rast_busy = 1'b0;
      forever begin
         @(negedge clock);
         if (!reset) busy_cnt = 0;
         else if (rast_valid && busy_len > 0) busy_cnt = busy_len;
         else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) fall_cyc = cyc;
         end
         rast_busy = hold_busy || (busy_cnt > 0);
      end
   end

   task automatic push(input logic [TRI_W-1:0] t, input logic last, input bit expect_issue);
      int budget = 200;
      @(negedge clock);
      while (!tri_ready && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      if (!tri_ready) begin
         check("push_ready_timeout", 32'd0, 32'd1);
         return;
      end
      tri_in    = t;
      tri_last  = last;
      tri_valid = 1'b1;
      if (expect_issue) exp_q.push_back('{t, last, exp_addr});
      @(posedge clock);
      #1 tri_valid = 1'b0;
   endtask

   task automatic wait_drain(input int settle);
      int budget = 2000;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      repeat (settle) @(negedge clock);
   endtask

   task automatic wait_issue(input int start);
      int budget = 100;
      while (n_issue == start && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      if (n_issue == start) check("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_frame_start(input logic [25:0] base);
      @(negedge clock);
      fb_base     = base;
      frame_start = 1'b1;
      @(posedge clock);
      #1 frame_start = 1'b0;
      fb_base = '0;
   endtask

   task automatic clear_board();
      exp_q.delete();
      exp_issued = 0;
      fd_expect  = 0;
      fd_seen    = 0;
      have_issue = 0;
      exp_addr   = '0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset     = 1'b0;
      hold_busy = 0;
      clear_board();
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      int start;
      #2 reset = 1'b0;
      #1;
      check("rst_tri_ready", 32'(tri_ready), 32'd0);
      check("rst_rast_valid", 32'(rast_valid), 32'd0);
      check("rst_rast_done", 32'(rast_done), 32'd0);
      check_w("rst_rast_tri", rast_tri, '0);
      check("rst_rast_addr", 32'(rast_addr), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_issued_cnt", 32'(issued_cnt), 32'd0);
      check("rst_culled_cnt", 32'(culled_cnt), 32'd0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("ready_after_reset", 32'(tri_ready), 32'd1);

      // Single triangle, rasterizer busy 20 cycles.
      busy_len = 20;
      push(mk(0, 0, 10, 0, 0, 10, 24'hff0000), 1'b1, 1);
      wait_drain(30);
      check("t1_fd_count", 32'(fd_seen), 32'd1);
      check("t1_fd_after_fall", 32'(fd_cyc - fall_cyc), 32'd1);
      check("t1_issued_cnt", 32'(issued_cnt), 32'd1);

      // Six back-to-back triangles with the rasterizer held busy.
      do_reset();
      busy_len  = 6;
      hold_busy = 1;
      repeat (2) @(negedge clock);
      for (int i = 0; i < 4; i++) push(mk(i, i + 1, i + 2, 3, 4, 5, 24'h010203 * 24'(i + 1)), 1'b0, 1);
      @(negedge clock);
      check("t2_full_after4", 32'(tri_ready), 32'd0);
      check("t2_held_no_issue", 32'(issued_cnt), 32'd0);
      hold_busy = 0;
      push(mk(20, 21, 22, 23, 24, 25, 24'habcdef), 1'b0, 1);
      push(mk(30, 31, 32, 33, 34, 35, 24'h123456), 1'b1, 1);
      wait_drain(20);
      check("t2_issued_cnt", 32'(issued_cnt), 32'd6);
      check("t2_fd_count", 32'(fd_seen), 32'd1);

      // Busy never rises: completion by timeout.
      do_reset();
      busy_len = 0;
      push(mk(1, 2, 3, 4, 5, 6, 24'h111111), 1'b1, 1);
      push(mk(7, 8, 9, 10, 11, 12, 24'h222222), 1'b0, 1);
      wait_drain(25);
      check("t3_issue_gap", 32'(last_issue_cyc - prev_issue_cyc), 32'd17);
      check("t3_fd_after_issue", 32'(fd_cyc - prev_issue_cyc), 32'd16);
      check("t3_issued_cnt", 32'(issued_cnt), 32'd2);
      check("t3_fd_count", 32'(fd_seen), 32'd1);

      // frame_start in IDLE applies at once; during WAIT_DONE it is deferred.
      do_reset();
      busy_len = 20;
      pulse_frame_start(26'h0000100);
      @(negedge clock);
      check("t4_addr_idle", 32'(rast_addr), 32'h0000100);
      exp_addr = 26'h0000100;
      start = n_issue;
      push(mk(2, 2, 50, 2, 2, 50, 24'h0000ff), 1'b0, 1);
      wait_issue(start);
      repeat (5) @(negedge clock);
      pulse_frame_start(26'h0123400);
      @(negedge clock);
      check("t4_addr_held", 32'(rast_addr), 32'h0000100);
      exp_addr = 26'h0123400;
      push(mk(3, 3, 60, 3, 3, 60, 24'h00ff00), 1'b1, 1);
      wait_drain(30);
      check("t4_addr_final", 32'(rast_addr), 32'h0123400);
      check("t4_fd_count", 32'(fd_seen), 32'd1);

      // Reset with one in flight and three queued.
      do_reset();
      busy_len = 30;
      pulse_frame_start(26'h2aaaaaa);
      exp_addr = 26'h2aaaaaa;
      start = n_issue;
      for (int i = 0; i < 4; i++) push(mk(5, 5, 15, 5, 5, 15 + i, 24'h0f0f0f), 1'(i == 3), 1);
      wait_issue(start);
      repeat (3) @(negedge clock);
      check("t5_queued", 32'(exp_q.size()), 32'd3);
      reset = 1'b0;
      #1;
      check("t5_rst_valid", 32'(rast_valid), 32'd0);
      check("t5_rst_done", 32'(rast_done), 32'd0);
      check_w("t5_rst_tri", rast_tri, '0);
      check("t5_rst_addr", 32'(rast_addr), 32'd0);
      check("t5_rst_issued", 32'(issued_cnt), 32'd0);
      check("t5_rst_ready", 32'(tri_ready), 32'd0);
      clear_board();
      start = n_issue;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (40) @(negedge clock);
      check("t5_no_issue", 32'(n_issue - start), 32'd0);
      check("t5_no_fd", 32'(fd_seen), 32'd0);
      check("t5_issued_cnt", 32'(issued_cnt), 32'd0);

      // Off-screen triangles: culled with the feature, issued without it.
      do_reset();
      busy_len = 3;
`ifdef CULL_OFFSCREEN_EN
      push(mk(700, 0, 700, 10, 700, 20, 24'h444444), 1'b1, 0);
      fd_expect++;
      repeat (10) @(negedge clock);
      check("t6_culled_cnt", 32'(culled_cnt), 32'd1);
      check("t6_issued_cnt", 32'(issued_cnt), 32'd0);
      check("t6_fd_count", 32'(fd_seen), 32'd1);
      push(mk(640, 0, 640, 10, 640, 20, 24'h555555), 1'b0, 0);
      push(mk(639, 0, 639, 10, 639, 20, 24'h666666), 1'b1, 1);
      wait_drain(10);
      check("t6_culled_cnt2", 32'(culled_cnt), 32'd2);
      check("t6_issued_cnt2", 32'(issued_cnt), 32'd1);
`else
      push(mk(700, 0, 700, 10, 700, 20, 24'h444444), 1'b1, 1);
      wait_drain(10);
      check("t6_issued_cnt", 32'(issued_cnt), 32'd1);
      check("t6_culled_cnt", 32'(culled_cnt), 32'd0);
      check("t6_fd_count", 32'(fd_seen), 32'd1);
      push(mk(640, 0, 640, 10, 640, 20, 24'h555555), 1'b0, 1);
      push(mk(639, 0, 639, 10, 639, 20, 24'h666666), 1'b1, 1);
      wait_drain(10);
      check("t6_issued_cnt2", 32'(issued_cnt), 32'd3);
      check("t6_culled_cnt2", 32'(culled_cnt), 32'd0);
`endif
      check("t6_fd_match", 32'(fd_seen), 32'(fd_expect));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/raster_tri_scheduler.md
Name: raster_tri_scheduler

Overview:
- Sequences triangle setup into the rasterizer: buffers incoming transformed triangles in a small FIFO, issues them one at a time when the rasterizer is idle, and tracks completion.
- Propagates the end-of-frame marker onto the rasterizer's done input, and pulses frame_done when the last triangle of the frame finishes.
- Sits between the vertex/transform stage and the rasterizer.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >= 2).
- TRI_W, 360, packed triangle width: {x1,y1,z1,x2,y2,z2,x3,y3,z3} as 9x32 signed 16.16, then {color1,color2,color3} as 3x24, MSB first.
- BUSY_TIMEOUT, 15, maximum cycles to wait for rast_busy to rise after an issue.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- tri_in  in  TRI_W  packed triangle
- tri_last  in  1  this triangle ends the frame
- tri_valid  in  1  producer has a triangle
- tri_ready  out  1  FIFO can accept (!full)
- fb_base  in  26  frame buffer base; sampled on frame_start
- frame_start  in  1  one-cycle pulse, latches fb_base
- rast_tri  out  TRI_W  triangle to rasterizer
- rast_addr  out  26  latched frame buffer base
- rast_valid  out  1  one-cycle issue strobe (rasterizer in_data_valid)
- rast_done  out  1  done_in to rasterizer (last flag of issued triangle)
- rast_busy  in  1  rasterizer not in its idle state
- frame_done  out  1  one-cycle pulse: last triangle of frame completed
- issued_cnt  out  16  triangles issued since reset (wraps)
- culled_cnt  out  16  triangles culled since reset (wraps; 0 when culling is compiled out)

Behaviour:
- Reset (async, active-low): FIFO emptied, state S_IDLE, tri_ready=0 while reset is asserted and 1 on the first cycle after release, rast_valid=0, rast_done=0, frame_done=0, rast_tri=0, rast_addr=0, both counters 0. Reset mid-frame drops all queued and in-flight triangles; no frame_done is produced for them.
- FIFO: push when tri_valid && tri_ready; each entry stores {tri_in, tri_last}. tri_ready = (count != DEPTH), computed from the registered count, so there is no same-cycle full bypass. A push and a pop in the same cycle leaves count unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - S_IDLE: if FIFO is non-empty and !rast_busy -> pop the head, register it onto rast_tri/rast_done, go to S_ISSUE. If the FIFO is empty, stay.
  - S_ISSUE: rast_valid=1 for exactly this cycle; issued_cnt++; go to S_WAIT_BUSY.
  - S_WAIT_BUSY: wait for rast_busy=1, then go to S_WAIT_DONE. If BUSY_TIMEOUT cycles pass with rast_busy=0, treat the triangle as complete (it was accepted and finished, or was zero-area) and take the completion path.
  - S_WAIT_DONE: on rast_busy falling to 0 -> completion path.
  - Completion path: if the completed triangle's last flag is set, frame_done=1 for one cycle. Return to S_IDLE.
- rast_tri, rast_done and rast_addr hold stable from S_ISSUE until the next issue.
- Minimum issue-to-issue spacing is 4 cycles.
- frame_start updates rast_addr only in S_IDLE. A frame_start arriving in any other state is held pending and applied on the next entry to S_IDLE, before the next issue.

Optional Feature:
- CULL_OFFSCREEN_EN:
  - When defined, the head entry is checked in S_IDLE before issue. If the integer bounding box of the three vertices (coordinate >>> 16) lies wholly outside 0..639 x 0..479, it is popped without issue and culled_cnt increments. Condition: maxX<0 or minX>639 or maxY<0 or minY>479.
  - If a culled entry has tri_last set, frame_done pulses in the same cycle.
  - Cull costs 1 cycle per entry.
- When not defined: every triangle is issued and culled_cnt stays 0.

Test Plan:
- Single triangle (0,0),(10,0),(0,10) with last=1, rast_busy modelled high for 20 cycles -> one rast_valid pulse, rast_done=1, frame_done one cycle after rast_busy falls, issued_cnt=1.
- Push 6 triangles back-to-back with the rasterizer busy -> tri_ready drops after 4 pushes; all 6 issued in order, each issue only after rast_busy falls; issued_cnt=6.
- rast_busy stuck at 0 after an issue -> completion after 15 cycles; the next triangle issues.
- frame_start with fb_base=0x0123400 during S_WAIT_DONE -> rast_addr still old; becomes 0x0123400 before the next rast_valid.
- Reset asserted with 3 queued and 1 in flight -> outputs zero immediately; after release, no rast_valid and no frame_done.
- CULL_OFFSCREEN_EN: triangle with all x = 700.0 and last=1 -> no rast_valid, culled_cnt=1, frame_done pulses; without the macro the same triangle is issued.
